// File: rtl/mult_requester.sv
// mult_requester: queues operand pairs, issues them one at a time to the
// multiplier over ready/Done_Flag/ack, and holds each product for downstream.
//
// Parameters:
//   DEPTH   - operand FIFO entries (power of two, >= 2)
//   TIMEOUT - max REQ cycles without Done_Flag (only with MULT_TIMEOUT_EN)
// Ports:
//   clk, reset (async, active low)
//   op_valid, op_a, op_b, op_full  - upstream operand push side
//   a, b, ready, Done_Flag, producto, ack - multiplier handshake
//   res_valid, res_data, res_take  - downstream result side
//   busy, err                      - status (err sticky timeout flag)
// Optional feature macro: MULT_TIMEOUT_EN (REQ watchdog, drives err).
module mult_requester #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        op_full,
   output logic [15:0] a,
   output logic [15:0] b,
   output logic        ready,
   input  logic        Done_Flag,
   input  logic [31:0] producto,
   output logic        ack,
   output logic        res_valid,
   output logic [31:0] res_data,
   input  logic        res_take,
   output logic        busy,
   output logic        err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, ACKW, DRAIN} state_t;

   state_t state_q, state_d;

   logic [31:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             full_q, full_d;
   logic             busy_q, busy_d;

   logic [15:0] a_q, a_d, b_q, b_d;
   logic        ready_q, ready_d;
   logic        ack_q, ack_d;
   logic        rv_q, rv_d;
   logic [31:0] rd_data_q, rd_data_d;

   logic        push, pop, tmo;
   logic [31:0] head;

   // Full check uses the registered flag, so a push while full is
   // dropped even when the same edge pops an entry.
   assign push = op_valid && !full_q;
   // A result slot frees up either already or at this very edge.
   assign pop  = (state_q == IDLE) && (cnt_q != '0) &&
                 (!rv_q || res_take);
   assign head = mem_q[rd_q];

`ifdef MULT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt_q;
   logic          err_q;

   assign tmo = (state_q == REQ) && !Done_Flag &&
                (tcnt_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         tcnt_q <= (state_q == REQ) ? tcnt_q + 1'b1 : '0;
         if (tmo) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   // Operand storage; pointers are reset, contents need not be.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {op_a, op_b};
   end

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   assign full_d = (cnt_d == FULL_CNT);
   assign busy_d = (state_d != IDLE) || (cnt_d != '0);

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (pop) state_d = REQ;
         REQ: begin
            if (Done_Flag) state_d = ACKW;
            else if (tmo)  state_d = DRAIN;
         end
         ACKW:  state_d = DRAIN;
         DRAIN: if (!Done_Flag) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs (next values of the output registers)
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      ready_d   = ready_q;
      ack_d     = 1'b0;
      rv_d      = rv_q && !res_take;
      rd_data_d = rd_data_q;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               a_d     = head[31:16];
               b_d     = head[15:0];
               ready_d = 1'b1;
            end
         end
         REQ: begin
            if (Done_Flag) begin
               rd_data_d = producto;
               rv_d      = 1'b1;
               ready_d   = 1'b0;
               ack_d     = 1'b1;
            end else if (tmo) begin
               ready_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         full_q    <= 1'b0;
         busy_q    <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         ready_q   <= 1'b0;
         ack_q     <= 1'b0;
         rv_q      <= 1'b0;
         rd_data_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         cnt_q     <= cnt_d;
         full_q    <= full_d;
         busy_q    <= busy_d;
         a_q       <= a_d;
         b_q       <= b_d;
         ready_q   <= ready_d;
         ack_q     <= ack_d;
         rv_q      <= rv_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign op_full   = full_q;
   assign busy      = busy_q;
   assign a         = a_q;
   assign b         = b_q;
   assign ready     = ready_q;
   assign ack       = ack_q;
   assign res_valid = rv_q;
   assign res_data  = rd_data_q;

endmodule
